// File: rtl/regfile_trace_monitor.sv
// Shadows core register-file writes and queues filtered writes into a show-ahead trace FIFO.
// Optional per-entry timestamps are enabled with the macro __TRACE_TIMESTAMP_EN.
module regfile_trace_monitor #(
  parameter  int XLEN  = 32,
  parameter  int NREGS = 32,
  parameter  int DEPTH = 16,
  parameter  int TSW   = 16,
  localparam int AW    = $clog2(NREGS),
  localparam int LW    = $clog2(DEPTH) + 1
) (
  input  logic             CLK,
  input  logic             RES,
  input  logic             EN,
  input  logic             FLUSH,
  input  logic             WE,
  input  logic [AW-1:0]    WADDR,
  input  logic [XLEN-1:0]  WDATA,
  input  logic [NREGS-1:0] MASK,
  input  logic [AW-1:0]    RD_IDX,
  output logic [XLEN-1:0]  RD_DATA,
  output logic             T_VALID,
  input  logic             T_READY,
  output logic [AW-1:0]    T_ADDR,
  output logic [XLEN-1:0]  T_DATA,
  output logic [TSW-1:0]   T_TIME,
  output logic [LW-1:0]    LEVEL,
  output logic             OVF,
  output logic [15:0]      DROPS
);

  localparam int PW = LW - 1;

  logic [XLEN-1:0] shadow_q [NREGS];
  logic [XLEN-1:0] shadow_d [NREGS];
  logic [XLEN-1:0] rd_data_q, rd_data_d;

  logic [AW-1:0]   mem_addr_q [DEPTH];
  logic [AW-1:0]   mem_addr_d [DEPTH];
  logic [XLEN-1:0] mem_data_q [DEPTH];
  logic [XLEN-1:0] mem_data_d [DEPTH];

  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic            ovf_q, ovf_d;
  logic [15:0]     drops_q, drops_d;

  logic wr_hit, push_req, t_valid, full, pop, push, drop;

  assign wr_hit   = WE && (WADDR != '0);
  assign push_req = EN && wr_hit && MASK[WADDR] && !FLUSH;
  assign t_valid  = (level_q != '0);
  assign full     = (level_q == LW'(DEPTH));
  assign pop      = t_valid && T_READY;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push     = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  always_comb begin
    shadow_d = shadow_q;
    if (wr_hit) shadow_d[WADDR] = WDATA;
    rd_data_d = (wr_hit && (WADDR == RD_IDX)) ? WDATA : shadow_q[RD_IDX];

    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    if (push) begin
      mem_addr_d[wr_ptr_q] = WADDR;
      mem_data_d[wr_ptr_q] = WDATA;
    end

    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    level_d  = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    ovf_d   = ovf_q | drop;
    drops_d = (drop && (drops_q != 16'hFFFF)) ? drops_q + 16'd1 : drops_q;

    if (FLUSH) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
      ovf_d    = 1'b0;
      drops_d  = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RES) begin
      for (int i = 0; i < NREGS; i++) shadow_q[i] <= '0;
      rd_data_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      ovf_q     <= 1'b0;
      drops_q   <= '0;
    end else begin
      shadow_q  <= shadow_d;
      rd_data_q <= rd_data_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      ovf_q     <= ovf_d;
      drops_q   <= drops_d;
    end
  end

  // Entry storage needs no reset: nothing is visible unless the level says so.
  always_ff @(posedge CLK) begin
    mem_addr_q <= mem_addr_d;
    mem_data_q <= mem_data_d;
  end

`ifdef __TRACE_TIMESTAMP_EN
  logic [TSW-1:0] ts_q, ts_d;
  logic [TSW-1:0] mem_time_q [DEPTH];
  logic [TSW-1:0] mem_time_d [DEPTH];

  always_comb begin
    ts_d       = ts_q + TSW'(1);
    mem_time_d = mem_time_q;
    if (push) mem_time_d[wr_ptr_q] = ts_q;
  end

  always_ff @(posedge CLK) begin
    if (!RES) ts_q <= '0;
    else      ts_q <= ts_d;
  end

  always_ff @(posedge CLK) begin
    mem_time_q <= mem_time_d;
  end

  assign T_TIME = t_valid ? mem_time_q[rd_ptr_q] : '0;
`else
  assign T_TIME = '0;
`endif

  assign RD_DATA = rd_data_q;
  assign T_VALID = t_valid;
  assign T_ADDR  = t_valid ? mem_addr_q[rd_ptr_q] : '0;
  assign T_DATA  = t_valid ? mem_data_q[rd_ptr_q] : '0;
  assign LEVEL   = level_q;
  assign OVF     = ovf_q;
  assign DROPS   = drops_q;

endmodule

// File: tb/tb_regfile_trace_monitor.sv
// Directed bench for regfile_trace_monitor with default parameters (NREGS=32, DEPTH=16).
module tb_regfile_trace_monitor;

  logic        CLK = 1'b0;
  logic        RES, EN, FLUSH, WE, T_READY;
  logic [4:0]  WADDR, RD_IDX, T_ADDR;
  logic [31:0] WDATA, MASK, RD_DATA, T_DATA;
  logic [15:0] T_TIME, DROPS;
  logic        T_VALID, OVF;
  logic [4:0]  LEVEL;

  int checks = 0;
  int errors = 0;

  regfile_trace_monitor dut (
    .CLK(CLK), .RES(RES), .EN(EN), .FLUSH(FLUSH), .WE(WE),
    .WADDR(WADDR), .WDATA(WDATA), .MASK(MASK), .RD_IDX(RD_IDX),
    .RD_DATA(RD_DATA), .T_VALID(T_VALID), .T_READY(T_READY),
    .T_ADDR(T_ADDR), .T_DATA(T_DATA), .T_TIME(T_TIME),
    .LEVEL(LEVEL), .OVF(OVF), .DROPS(DROPS)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [15:0] t0, t1, tdiff;

  initial begin
    RES = 1'b0; EN = 1'b0; FLUSH = 1'b0; WE = 1'b0; T_READY = 1'b0;
    WADDR = '0; WDATA = '0; MASK = '0; RD_IDX = '0;
    tick(); tick();
    chk("rst_valid", T_VALID, 1'b0);
    chk("rst_level", LEVEL, 5'd0);
    chk("rst_rd", RD_DATA, 32'd0);
    chk("rst_ovf", OVF, 1'b0);
    chk("rst_drops", DROPS, 16'd0);
    chk("rst_head", {T_ADDR, T_DATA, T_TIME}, 53'd0);
    RES = 1'b1;

    // first capture with same-cycle read bypass
    WE = 1'b1; WADDR = 5'd5; WDATA = 32'hDEADBEEF; MASK = '1; EN = 1'b1; RD_IDX = 5'd5;
    tick();
    chk("byp_rd", RD_DATA, 32'hDEADBEEF);
    chk("cap_valid", T_VALID, 1'b1);
    chk("cap_addr", T_ADDR, 5'd5);
    chk("cap_data", T_DATA, 32'hDEADBEEF);
    chk("cap_level", LEVEL, 5'd1);

    // x0 is never written nor captured
    WADDR = 5'd0; WDATA = 32'h1234; RD_IDX = 5'd0;
    tick();
    chk("x0_rd", RD_DATA, 32'd0);
    chk("x0_level", LEVEL, 5'd1);

    WE = 1'b0; T_READY = 1'b1; RD_IDX = 5'd5;
    tick();
    chk("pop_level", LEVEL, 5'd0);
    chk("pop_valid", T_VALID, 1'b0);
    chk("shadow_x5", RD_DATA, 32'hDEADBEEF);

    // fill, then overflow by three
    T_READY = 1'b0;
    for (int i = 0; i < 16; i++) begin
      WE = 1'b1; WADDR = 5'(i + 1); WDATA = 32'hA000_0000 + i;
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      WADDR = 5'd20; WDATA = 32'hD0D0_0000 + i;
      tick();
    end
    WE = 1'b0;
    tick();
    chk("ovf_level", LEVEL, 5'd16);
    chk("ovf_flag", OVF, 1'b1);
    chk("ovf_drops", DROPS, 16'd3);
    T_READY = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("drain1_%0d", i), {T_VALID, T_ADDR, T_DATA}, {1'b1, 5'(i + 1), 32'hA000_0000 + i});
      tick();
    end
    chk("drain1_level", LEVEL, 5'd0);
    chk("drain1_ovf_sticky", OVF, 1'b1);

    // flush with pending entries and a simultaneous write
    T_READY = 1'b0; WE = 1'b1; WADDR = 5'd3; WDATA = 32'h3333;
    tick(); tick();
    FLUSH = 1'b1; WADDR = 5'd7; WDATA = 32'h0000_0077;
    tick();
    FLUSH = 1'b0; WE = 1'b0; RD_IDX = 5'd7;
    chk("flush_level", LEVEL, 5'd0);
    chk("flush_valid", T_VALID, 1'b0);
    chk("flush_ovf", OVF, 1'b0);
    chk("flush_drops", DROPS, 16'd0);
    tick();
    chk("flush_x7", RD_DATA, 32'h0000_0077);
    chk("flush_nocap", LEVEL, 5'd0);

    // full FIFO, push and pop together
    for (int i = 0; i < 16; i++) begin
      WE = 1'b1; WADDR = 5'(i + 1); WDATA = 32'hB000_0000 + i;
      tick();
    end
    WADDR = 5'd9; WDATA = 32'hCAFE_0000; T_READY = 1'b1;
    tick();
    WE = 1'b0;
    chk("pp_level", LEVEL, 5'd16);
    chk("pp_ovf", OVF, 1'b0);
    chk("pp_drops", DROPS, 16'd0);
    for (int i = 0; i < 16; i++) begin
      if (i < 15)
        chk($sformatf("drain2_%0d", i), {T_VALID, T_ADDR, T_DATA}, {1'b1, 5'(i + 2), 32'hB000_0001 + i});
      else
        chk("drain2_last", {T_VALID, T_ADDR, T_DATA}, {1'b1, 5'd9, 32'hCAFE_0000});
      tick();
    end
    chk("drain2_empty", T_VALID, 1'b0);

    // mask filter
    T_READY = 1'b0; MASK = 32'h0000_0004;
    WE = 1'b1; WADDR = 5'd1; WDATA = 32'h11; tick();
    WADDR = 5'd2; WDATA = 32'h22; tick();
    WADDR = 5'd3; WDATA = 32'h33; tick();
    WE = 1'b0; RD_IDX = 5'd1;
    chk("mask_level", LEVEL, 5'd1);
    chk("mask_head", {T_ADDR, T_DATA}, {5'd2, 32'h22});
    tick();
    chk("mask_x1", RD_DATA, 32'h11);
    RD_IDX = 5'd2; tick();
    chk("mask_x2", RD_DATA, 32'h22);
    RD_IDX = 5'd3; tick();
    chk("mask_x3", RD_DATA, 32'h33);
    T_READY = 1'b1; tick();
    chk("mask_pop", LEVEL, 5'd0);

    // capture disabled
    T_READY = 1'b0; MASK = '1; EN = 1'b0; WE = 1'b1; WADDR = 5'd4; WDATA = 32'h44;
    tick();
    WE = 1'b0;
    chk("en0_level", LEVEL, 5'd0);
    EN = 1'b1;

    // timestamps: two writes ten cycles apart
    WE = 1'b1; WADDR = 5'd6; WDATA = 32'h60; tick();
    WE = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    WE = 1'b1; WDATA = 32'h61; tick();
    WE = 1'b0;
    chk("ts_level", LEVEL, 5'd2);
    t0 = T_TIME;
    T_READY = 1'b1; tick();
    T_READY = 1'b0;
    t1 = T_TIME;
    chk("ts_second", T_DATA, 32'h61);
    tdiff = t1 - t0;
`ifdef __TRACE_TIMESTAMP_EN
    chk("ts_diff", tdiff, 16'd10);
`else
    chk("ts_zero", {t0, t1}, 32'd0);
`endif

    // reset mid-drain discards entries and clears shadow
    RES = 1'b0; RD_IDX = 5'd2;
    tick();
    RES = 1'b1;
    chk("rst2_level", LEVEL, 5'd0);
    chk("rst2_valid", T_VALID, 1'b0);
    tick();
    chk("rst2_shadow", RD_DATA, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
